mem_stream_engine: RTL and testbench
====================================

Name: mem_stream_engine

Overview:
Parametrised read→process→write streaming engine for the sample-memory path. On a start command it reads a block of samples from a source RAM, presents them to an external processing chain of fixed latency, and writes the results to a destination RAM. The write address is delayed to match the total read-plus-processing latency. It replaces ad-hoc address delay chains with a controlled, length-bounded, abortable transfer and a busy/done handshake.

Parameters:
DATA_W, 16, sample width in bits
ADDR_W, 16, RAM address width; addresses wrap modulo 2^ADDR_W
RD_LAT, 1, source RAM read latency in cycles, from rd_en to rd_data valid (≥1)
PROC_LAT, 2, processing-chain latency in cycles, from proc_in to proc_out (≥0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe; honoured only in IDLE
bypass  in  1  sampled with start; 1 routes rd_data directly to wr_data, skipping the processing chain
base_rd  in  ADDR_W  source start address, sampled with start
base_wr  in  ADDR_W  destination start address, sampled with start
length  in  ADDR_W  number of samples, sampled with start
abort  in  1  stop issuing reads; in-flight samples still drain
rd_en  out  1  source RAM read enable
rd_addr  out  ADDR_W  source RAM address
rd_data  in  DATA_W  source RAM data
proc_in  out  DATA_W  to processing chain; equals rd_data
proc_in_valid  out  1  qualifies proc_in
proc_out  in  DATA_W  from processing chain
wr_en  out  1  destination RAM write enable
wr_addr  out  ADDR_W  destination RAM address
wr_data  out  DATA_W  destination RAM data
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
aborted  out  1  valid with done; 1 if the transfer ended by abort
wr_count  out  ADDR_W  writes performed in the current or last transfer

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. rd_en, wr_en, proc_in_valid, busy, done and aborted are 0. rd_addr, wr_addr, wr_data and wr_count are 0. All delay-pipeline valid bits are cleared. Reset mid-transfer discards all in-flight samples; no further writes occur.
- Total latency L = RD_LAT + PROC_LAT (normal) or RD_LAT (bypass). The mode is latched at start.
- States:
  - IDLE: start=1 latches base_rd, base_wr, length and bypass; clears wr_count; next state ISSUE, or DRAIN if length=0.
  - ISSUE: rd_en=1 every cycle. rd_addr=base_rd+i for i=0..length-1. Leaves for DRAIN after issuing the last read, or on abort=1; the read in the abort cycle is suppressed.
  - DRAIN: no reads. Waits until the delay pipeline holds no valid entries, then moves to DONE.
  - DONE: done=1 for one cycle; aborted holds the latched abort flag; busy=0 in this cycle. Next state IDLE.
- Delay pipeline: shift register of {valid, wr_addr} with depth RD_LAT+PROC_LAT. The write tap is selected by the latched mode. A read issued at cycle k produces wr_en=1 at cycle k+L, with wr_addr=base_wr+i.
- wr_data source: proc_out in normal mode, rd_data in bypass.
- proc_in_valid is the valid bit at RD_LAT stages. proc_in is driven continuously in both modes.
- wr_count increments on each wr_en, modulo 2^ADDR_W.
- start while busy: ignored, no effect. abort outside ISSUE: ignored.
- Address arithmetic wraps. For example, base_rd=16'hFFFF with length 2 reads FFFF, then 0000.
- Cycle accounting: start accepted at cycle 0 → first rd_en at cycle 1 → last write at cycle length+L → done at cycle length+L+1. For length=0, done occurs at cycle 2.

Decomposition:
- Shared package mem_stream_pkg holds:
  - state enum typedef (IDLE, ISSUE, DRAIN, DONE)
  - typedef for the pipeline entry struct {valid, addr}
  - default width constants DATA_W_DEF=16 and ADDR_W_DEF=16.
- One natural sub-module: addr_delay_line. It is a parametrised shift register of {valid, addr} with depth RD_LAT+PROC_LAT and a runtime-selectable tap. It exposes an any_valid output used by DRAIN.

Test Plan:
- Normal run: RD_LAT=1, PROC_LAT=2, base_rd=0, base_wr=16'h100, length=8, with the bench modelling the processing chain as +1. Expected: wr_en at cycles 4..11, wr_addr 100..107, wr_data=mem[i]+1, done at cycle 12, wr_count=8, aborted=0.
- Bypass run: same setup with bypass=1. Expected: writes at cycles 2..9 with wr_data=mem[i], done at cycle 10.
- Wrap: base_rd=16'hFFFE, base_wr=16'hFFFF, length=3. Expected: rd_addr FFFE, FFFF, 0000 and wr_addr FFFF, 0000, 0001.
- Zero length and busy start: length=0 → no rd_en or wr_en, done at cycle 2. A second start pulsed mid-transfer → ignored, and the transfer count is unchanged.
- Abort: length=100 with abort at cycle 5. Expected: reads at cycles 1..4 only, exactly 4 writes, done=1 with aborted=1, wr_count=4.
- Async reset mid-transfer: rst_n low at cycle 6 → all outputs 0 immediately, no writes after release. A following start runs normally.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and default widths for the sample-memory streaming engine.
package mem_stream_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
    } pipe_entry_t;

endpackage

// File: rtl/mem_stream_engine_addr_delay_line.sv
// Shift register of {valid, write address} with a mode-selectable write tap.
module addr_delay_line #(
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int PROC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              tap_sel,
    output logic              tap_valid,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              mid_valid,
    output logic              any_valid
);

    localparam int DEPTH    = RD_LAT + PROC_LAT;
    localparam int TAP_FULL = DEPTH - 1;
    localparam int TAP_BYP  = RD_LAT - 1;

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] addr_r [DEPTH];

    // Stage 0 captures the read issued this cycle; later stages age by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            for (int j = 0; j < DEPTH; j++) addr_r[j] <= {ADDR_W{1'b0}};
        end else begin
            valid_r[0] <= in_valid;
            addr_r[0]  <= in_addr;
            for (int j = 1; j < DEPTH; j++) begin
                valid_r[j] <= valid_r[j-1];
                addr_r[j]  <= addr_r[j-1];
            end
        end
    end

    // any_valid only looks upstream of the tap: once it drops, the entry now
    // at the tap is the last write of the transfer.
    always_comb begin
        any_valid = 1'b0;
        if (tap_sel) begin
            tap_valid = valid_r[TAP_BYP];
            tap_addr  = addr_r[TAP_BYP];
            for (int j = 0; j < TAP_BYP; j++) any_valid = any_valid | valid_r[j];
        end else begin
            tap_valid = valid_r[TAP_FULL];
            tap_addr  = addr_r[TAP_FULL];
            for (int j = 0; j < TAP_FULL; j++) any_valid = any_valid | valid_r[j];
        end
        mid_valid = valid_r[TAP_BYP];
    end

endmodule

// File: rtl/mem_stream_engine.sv
// Read -> process -> write streaming engine with latency-matched write addressing,
// abortable issue phase and busy/done handshake.
module mem_stream_engine
    import mem_stream_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int PROC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bypass,
    input  logic [ADDR_W-1:0] base_rd,
    input  logic [ADDR_W-1:0] base_wr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] proc_in,
    output logic              proc_in_valid,
    input  logic [DATA_W-1:0] proc_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] wr_count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] rd_addr_r, wr_ptr_r, remain_r, wr_count_r;
    logic              bypass_r, abort_flag_r;
    logic              accept_s, issue_s;
    logic              tap_valid_s, mid_valid_s, any_valid_s;
    logic [ADDR_W-1:0] tap_addr_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Next-state and control decode; a read is suppressed in the abort cycle
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
                if (start) state_next_s = (length == ADDR_ZERO) ? DRAIN : ISSUE;
                else       state_next_s = IDLE;
            end
            ISSUE: begin
                busy    = 1'b1;
                issue_s = !abort;
                if (abort || remain_r == ADDR_ONE) state_next_s = DRAIN;
                else                               state_next_s = ISSUE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (any_valid_s) state_next_s = DRAIN;
                else             state_next_s = DONE;
            end
            DONE: begin
                done         = 1'b1;
                state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Transfer context: addresses, remaining count, mode and abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r    <= ADDR_ZERO;
            wr_ptr_r     <= ADDR_ZERO;
            remain_r     <= ADDR_ZERO;
            bypass_r     <= 1'b0;
            abort_flag_r <= 1'b0;
        end else if (accept_s) begin
            rd_addr_r    <= base_rd;
            wr_ptr_r     <= base_wr;
            remain_r     <= length;
            bypass_r     <= bypass;
            abort_flag_r <= 1'b0;
        end else if (issue_s) begin
            rd_addr_r <= rd_addr_r + ADDR_ONE;
            wr_ptr_r  <= wr_ptr_r + ADDR_ONE;
            remain_r  <= remain_r - ADDR_ONE;
        end else if (state_r == ISSUE) begin
            abort_flag_r <= 1'b1;
        end
    end

    // Write counter, cleared by each accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           wr_count_r <= ADDR_ZERO;
        else if (accept_s)    wr_count_r <= ADDR_ZERO;
        else if (tap_valid_s) wr_count_r <= wr_count_r + ADDR_ONE;
    end

    addr_delay_line #(
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .PROC_LAT (PROC_LAT)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue_s),
        .in_addr   (wr_ptr_r),
        .tap_sel   (bypass_r),
        .tap_valid (tap_valid_s),
        .tap_addr  (tap_addr_s),
        .mid_valid (mid_valid_s),
        .any_valid (any_valid_s)
    );

    assign rd_en         = issue_s;
    assign rd_addr       = rd_addr_r;
    assign proc_in       = rd_data;
    assign proc_in_valid = mid_valid_s;
    assign wr_en         = tap_valid_s;
    assign wr_addr       = tap_addr_s;
    assign wr_data       = tap_valid_s ? (bypass_r ? rd_data : proc_out) : {DATA_W{1'b0}};
    assign aborted       = done & abort_flag_r;
    assign wr_count      = wr_count_r;

endmodule

// File: tb/tb_mem_stream_engine.sv
// Scoreboard bench: expected reads/writes/done are queued per transfer, a negedge monitor compares.
module tb_mem_stream_engine;

    localparam int RD_LAT   = 1;
    localparam int PROC_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, bypass = 1'b0, abort = 1'b0;
    logic [15:0] base_rd = 16'd0, base_wr = 16'd0, length = 16'd0;
    logic        rd_en, proc_in_valid, wr_en, busy, done, aborted;
    logic [15:0] rd_addr, wr_addr, wr_count;
    logic [15:0] rd_data = 16'd0, proc_in, proc_out = 16'd0, wr_data, p1 = 16'd0;

    always #5 clk = ~clk;

    mem_stream_engine #(.DATA_W(16), .ADDR_W(16), .RD_LAT(RD_LAT), .PROC_LAT(PROC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bypass(bypass),
        .base_rd(base_rd), .base_wr(base_wr), .length(length), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .proc_in(proc_in), .proc_in_valid(proc_in_valid), .proc_out(proc_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .aborted(aborted), .wr_count(wr_count)
    );

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         rdq[$], wrq[$], dnq[$];
    logic [15:0] mem [65536];
    int          cyc = 0, t0 = 0, exp_end = 0;
    bit          active = 1'b0;
    int          n_checks = 0, n_fail = 0;
    int          mon_rel;
    ev_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM (1-cycle read) and +1 processing chain (2 cycles)
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        p1       <= proc_in + 16'd1;
        proc_out <= p1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_piv"}, proc_in_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_count"}, wr_count, 0);
    endtask

    // Monitor: pop expectations whenever the DUT reads, writes or completes
    always @(negedge clk) begin
        if (rst_n) begin
            mon_rel = cyc - t0;
            if (rd_en) begin
                if (rdq.size() == 0) check("rd_unexpected", rd_en, 0);
                else begin
                    mon_e = rdq.pop_front();
                    check("rd_addr", rd_addr, mon_e.addr);
                    check("rd_cycle", mon_rel, mon_e.cyc);
                end
            end
            if (wr_en) begin
                if (wrq.size() == 0) check("wr_unexpected", wr_en, 0);
                else begin
                    mon_e = wrq.pop_front();
                    check("wr_addr", wr_addr, mon_e.addr);
                    check("wr_data", wr_data, mon_e.data);
                    check("wr_cycle", mon_rel, mon_e.cyc);
                end
            end
            if (done) begin
                if (dnq.size() == 0) check("done_unexpected", done, 0);
                else begin
                    mon_e = dnq.pop_front();
                    check("done_cycle", mon_rel, mon_e.cyc);
                    check("aborted", aborted, mon_e.addr);
                    check("wr_count", wr_count, mon_e.data);
                end
            end
            if (active) check("busy", busy, (mon_rel >= 1 && mon_rel < exp_end) ? 1 : 0);
        end
    end

    // One transfer: expected reads at cycles 1..n, writes L later, done after the
    // last write and at least one drain cycle. rst_at>0 pulls reset in that cycle.
    task automatic run_xfer(input bit byp, input logic [15:0] brd, input logic [15:0] bwr,
                            input logic [15:0] len, input int abort_at, input int busy_at,
                            input int rst_at);
        int  n, e_last, lat, lw, dcyc, limit;
        bit  ab;
        ev_t ev;
        n = int'(len); e_last = int'(len); ab = 1'b0;
        if (abort_at >= 1 && abort_at <= int'(len)) begin
            n = abort_at - 1; e_last = abort_at; ab = 1'b1;
        end
        lat  = byp ? RD_LAT : RD_LAT + PROC_LAT;
        lw   = (n > 0) ? n + lat : 0;
        dcyc = ((e_last + 1 > lw) ? e_last + 1 : lw) + 1;
        for (int i = 0; i < n; i++) begin
            ev.cyc = 1 + i; ev.addr = 16'(brd + 16'(i)); ev.data = 16'd0;
            if (rst_at == 0 || ev.cyc < rst_at) rdq.push_back(ev);
            ev.cyc  = 1 + i + lat;
            ev.data = mem[ev.addr] + (byp ? 16'd0 : 16'd1);
            ev.addr = 16'(bwr + 16'(i));
            if (rst_at == 0 || ev.cyc < rst_at) wrq.push_back(ev);
        end
        if (rst_at == 0) begin
            ev.cyc = dcyc; ev.addr = {15'd0, ab}; ev.data = 16'(n);
            dnq.push_back(ev);
            exp_end = dcyc; limit = dcyc + 3;
        end else begin
            exp_end = rst_at; limit = rst_at + 12;
        end
        @(posedge clk); #1;
        start = 1'b1; bypass = byp; base_rd = brd; base_wr = bwr; length = len;
        t0 = cyc; active = 1'b1;
        for (int r = 1; r <= limit; r++) begin
            @(posedge clk); #1;
            start = (r == busy_at);
            abort = (r == abort_at);
            if (r == busy_at) begin
                base_rd = 16'($urandom); base_wr = 16'($urandom); length = 16'd5; bypass = ~byp;
            end
            if (r == rst_at) begin
                rst_n = 1'b0;
                #1 check_idle("rst_mid");
            end
            if (rst_at > 0 && r == rst_at + 2) rst_n = 1'b1;
        end
        active = 1'b0; start = 1'b0; abort = 1'b0;
        check("rd_left", rdq.size(), 0);
        check("wr_left", wrq.size(), 0);
        check("done_left", dnq.size(), 0);
        rdq.delete(); wrq.delete(); dnq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, ab_at;
        bit byp;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        rst_n = 1'b1;
        run_xfer(1'b0, 16'h0000, 16'h0100, 16'd8,   0, 0, 0);  // normal
        run_xfer(1'b1, 16'h0000, 16'h0100, 16'd8,   0, 0, 0);  // bypass
        run_xfer(1'b0, 16'hFFFE, 16'hFFFF, 16'd3,   0, 0, 0);  // wrap
        run_xfer(1'b0, 16'h1234, 16'h4321, 16'd0,   0, 0, 0);  // zero length
        run_xfer(1'b0, 16'h0040, 16'h0200, 16'd10,  0, 3, 0);  // start while busy
        run_xfer(1'b0, 16'h0000, 16'h0300, 16'd100, 5, 0, 0);  // abort
        run_xfer(1'b0, 16'h0010, 16'h0400, 16'd8,   0, 0, 6);  // reset mid-transfer
        run_xfer(1'b0, 16'h0020, 16'h0500, 16'd8,   0, 0, 0);  // normal after reset
        for (int k = 0; k < 12; k++) begin
            len   = int'($urandom_range(0, 20));
            byp   = 1'($urandom_range(0, 1));
            ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len + 2)) : 0;
            run_xfer(byp, 16'($urandom), 16'($urandom), 16'(len), ab_at, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
